// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the MEM-stage decode.
package dmem_ctrl_pkg;

  // Controller FSM encodings
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Memory opcodes, shared with the MEM stage decoder
  localparam logic [3:0] LW = 4'b1000;
  localparam logic [3:0] SW = 4'b1001;

  // Width of the stall statistics counter and of the wait counter
  localparam int CNT_W = 16;

  // True when an opcode touches data memory
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bus bundle between MEM stage, controller and data memory.
// slave  : the controller's view
// master : the pipeline / memory side's view
interface dmem_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wrt;
  logic [DW-1:0] mem_rd;
  logic          stall;
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wrt, dm_rdata, dm_ack,
    output mem_rd, stall, dm_req, dm_wr, dm_addr, dm_wdata
  );

  modport master (
    output mem_re, mem_we, mem_addr, mem_wrt, dm_rdata, dm_ack,
    input  mem_rd, stall, dm_req, dm_wr, dm_addr, dm_wdata
  );
endinterface

// File: rtl/dmem_timeout_ctr.sv
// Loadable wait counter; o_tc flags the cycle in which the TC-th enabled
// cycle is being spent. TC = 0 disables the terminal count entirely.
module dmem_timeout_ctr #(
  parameter int W  = 16,
  parameter int TC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  logic [W-1:0] r_cnt;

  // Count enabled cycles from zero; hold at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (i_load)                 r_cnt <= '0;
    else if (i_en && (r_cnt != '1))  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (TC != 0) && i_en && (r_cnt == W'(TC - 1));
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns MEM-stage load/store strobes into a held
// req/ack transaction and freezes the pipeline until the access completes.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  dmem_ctrl_if.slave       bus,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  state_e           r_state;
  logic             r_req;
  logic             r_wr;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [DW-1:0]    r_rd;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_strobe;
  logic w_stall;
  logic w_tc;

  assign w_strobe = bus.mem_re | bus.mem_we;

  // Hold the MEM instruction from the cycle its strobe appears until DONE.
  // Gated by rst so the pipeline is released the instant reset is applied.
  assign w_stall = !rst && (((r_state == IDLE) && w_strobe) || (r_state == BUSY));

  dmem_timeout_ctr #(
    .W  (CNT_W),
    .TC (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == IDLE),
    .i_en   (r_state == BUSY),
    .o_tc   (w_tc)
  );

  // Main FSM with registered request, address, data, read-back and error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_strobe) begin
            // a store wins over a simultaneous load; the load is dropped
            r_addr  <= bus.mem_addr;
            r_wdata <= bus.mem_wrt;
            r_wr    <= bus.mem_we;
            r_req   <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.dm_ack) begin
            r_req <= 1'b0;
            if (!r_wr) r_rd <= bus.dm_rdata;
            r_state <= DONE;
          end else if (w_tc) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_rd    <= '1;
            r_state <= DONE;
          end
        end
        // strobes here still belong to the finished instruction
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.stall    = w_stall;
  assign bus.dm_req   = r_req;
  assign bus.dm_wr    = r_wr;
  assign bus.dm_addr  = r_addr;
  assign bus.dm_wdata = r_wdata;
  assign bus.mem_rd   = r_rd;
  assign err          = r_err;
  assign stall_cnt    = r_stall_cnt;
endmodule
